// File: rtl/q2_pkg.sv
// q2_pkg: shared definitions for the q2 sequencer slice.
//   state_e   - 4-bit state code {s3,s2,s1,s0} seen by q2_control
//   phase_e   - 2-bit phase within a state (settle / write / decide)
//   is_alu_op - decodes the bit-serial ALU instruction class from O
package q2_pkg;

  typedef enum logic [3:0] {
    ST_FETCH = 4'b0000,
    ST_DEREF = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_EXEC  = 4'b0011,
    ST_ALU   = 4'b0100
  } state_e;

  typedef enum logic [1:0] {
    PH_SETTLE = 2'd0,
    PH_WRITE  = 2'd1,
    PH_DECIDE = 2'd2
  } phase_e;

  function automatic logic is_alu_op(input logic o2, input logic o1, input logic o0);
    return !o2 && (o1 || o0);
  endfunction

endpackage

// File: rtl/q2_phase_gen.sv
// q2_phase_gen: three-phase counter (settle, write, decide) for one state.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (to settle, ws low)
//   hold      - freeze the current phase (used while the CPU is halted)
//   clear     - force the settle phase on the next clock (error recovery)
//   phase     - current phase code
//   last      - current phase is the decide phase
//   ws        - registered write strobe, high exactly in the write phase
module q2_phase_gen
  import q2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       clear,
  output logic [1:0] phase,
  output logic       last,
  output logic       ws
);

  phase_e phase_q, phase_d;
  logic   ws_q, ws_d;

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = PH_SETTLE;
    end else if (!hold) begin
      case (phase_q)
        PH_SETTLE: phase_d = PH_WRITE;
        PH_WRITE:  phase_d = PH_DECIDE;
        default:   phase_d = PH_SETTLE; // decide wraps; unused code 11 recovers
      endcase
    end
    // ws is a flop tracking the next phase so it lines up with phase_q
    ws_d = (phase_d == PH_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_SETTLE;
      ws_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ws_q    <= ws_d;
    end
  end

  assign phase = phase_q;
  assign last  = (phase_q == PH_DECIDE);
  assign ws    = ws_q;

endmodule

// File: rtl/q2_sequencer.sv
// q2_sequencer: master timing/state sequencer for the q2 CPU.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   run_sw              - free-run while high
//   step_sw             - one-cycle pulse, run one instruction while halted
//   deref, o0, o1, o2   - instruction decode inputs (valid from FETCH decide)
//   s0..s3              - registered state code for q2_control
//   ws                  - registered write strobe (write phase of a state)
//   halted              - parked at FETCH settle phase
//   alu_busy            - registered, high while in the ALU state
module q2_sequencer
  import q2_pkg::*;
#(
  parameter int unsigned ALU_STEPS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run_sw,
  input  logic step_sw,
  input  logic deref,
  input  logic o0,
  input  logic o1,
  input  logic o2,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic ws,
  output logic halted,
  output logic alu_busy
);

  localparam int unsigned CW = $clog2(ALU_STEPS + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halted_q, halted_d;
  logic          alu_busy_q, alu_busy_d;
  logic          clear;
  logic [1:0]    phase;
  logic          last;

  q2_phase_gen u_phase (
    .clk   (clk),
    .rst   (rst),
    .hold  (halted_q),
    .clear (clear),
    .phase (phase),
    .last  (last),
    .ws    (ws)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    clear    = 1'b0;

    // Halted anywhere other than FETCH/settle can only come from an upset.
    if (halted_q && (state_q != ST_FETCH || phase != PH_SETTLE)) begin
      state_d  = ST_FETCH;
      cnt_d    = '0;
      clear    = 1'b1;
    end else if (halted_q) begin
      if (run_sw || step_sw) halted_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: if (last) begin
          if (deref)   state_d = ST_DEREF;
          else if (!o2) state_d = ST_LOAD;
          else          state_d = ST_EXEC;
        end
        ST_DEREF: if (last) begin
          if (!o2) state_d = ST_LOAD;
          else     state_d = ST_EXEC;
        end
        ST_LOAD: if (last) begin
          if (is_alu_op(o2, o1, o0)) state_d = ST_ALU;
          else                       state_d = ST_EXEC;
        end
        ST_ALU: if (last) begin
          if (cnt_q < CW'(ALU_STEPS - 1)) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d   = '0;
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: if (last) begin
          state_d  = ST_FETCH;
          halted_d = !run_sw;
        end
        default: begin
          state_d  = ST_FETCH;
          cnt_d    = '0;
          halted_d = 1'b1;
          clear    = 1'b1;
        end
      endcase
    end

    alu_busy_d = (state_d == ST_ALU);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      cnt_q      <= '0;
      halted_q   <= 1'b1;
      alu_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
      alu_busy_q <= alu_busy_d;
    end
  end

  assign {s3, s2, s1, s0} = state_q;
  assign halted   = halted_q;
  assign alu_busy = alu_busy_q;

endmodule

// File: tb/tb_q2_sequencer.sv
// tb_q2_sequencer: directed self-checking bench for q2_sequencer (ALU_STEPS=8).
module tb_q2_sequencer;
  import q2_pkg::*;

  logic clk = 1'b0;
  logic rst, run_sw, step_sw, deref, o0, o1, o2;
  logic s0, s1, s2, s3, ws, halted, alu_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [3:0] seq [0:15];

  q2_sequencer #(.ALU_STEPS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_sw   (run_sw),
    .step_sw  (step_sw),
    .deref    (deref),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .s0       (s0),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .ws       (ws),
    .halted   (halted),
    .alu_busy (alu_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {s3, s2, s1, s0, ws, halted, alu_busy};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {s,ws,halted,busy}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic b2, input logic b1, input logic b0, input logic d);
    o2 = b2; o1 = b1; o0 = b0; deref = d;
  endtask

  // Walks n states of seq[] three clocks each, starting at FETCH settle of
  // the first instruction; optionally drops run_sw at the start of one state
  // and pulses step_sw during the decide phase of another.
  task automatic run_states(input string tag, input int unsigned n, input int drop_at,
                            input int pulse_at, input logic exp_halt,
                            input int unsigned exp_ws, input int unsigned exp_busy);
    int unsigned ws_n;
    int unsigned busy_n;
    ws_n = 0;
    busy_n = 0;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned p = 0; p < 3; p++) begin
        if (int'(i) == drop_at && p == 0) run_sw = 1'b0;
        check(tag, outs(), {seq[i], (p == 1), 1'b0, (seq[i] == ST_ALU)});
        if (ws) ws_n++;
        if (alu_busy) busy_n++;
        if (int'(i) == pulse_at && p == 2) step_sw = 1'b1;
        tick();
        step_sw = 1'b0;
      end
    end
    check({tag, "_end"}, outs(), {ST_FETCH, 1'b0, exp_halt, 1'b0});
    check_n({tag, "_ws_count"}, ws_n, exp_ws);
    check_n({tag, "_busy_count"}, busy_n, exp_busy);
  endtask

  task automatic add_seq(input logic with_deref);
    int unsigned k;
    k = 0;
    seq[k++] = ST_FETCH;
    if (with_deref) seq[k++] = ST_DEREF;
    seq[k++] = ST_LOAD;
    for (int unsigned j = 0; j < 8; j++) seq[k++] = ST_ALU;
    seq[k] = ST_EXEC;
  endtask

  initial begin
    rst = 1'b1; run_sw = 1'b0; step_sw = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0);

    // Power-on reset
    tick(); tick();
    check("reset_asserted", outs(), {ST_FETCH, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;
    tick();
    check("reset_released", outs(), {ST_FETCH, 1'b0, 1'b1, 1'b0});

    // Reset held two clocks in the middle of an ALU instruction
    set_op(1'b0, 1'b1, 1'b0, 1'b0);
    step_sw = 1'b1; tick(); step_sw = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_alu", outs(), {ST_ALU, 1'b1, 1'b0, 1'b1});
    rst = 1'b1;
    tick();
    check("reset_mid_alu_1", outs(), {ST_FETCH, 1'b0, 1'b1, 1'b0});
    tick();
    rst = 1'b0;
    check("reset_mid_alu_2", outs(), {ST_FETCH, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_halted", outs(), {ST_FETCH, 1'b0, 1'b1, 1'b0});
    end

    // Step: add with deref -> 12 states, 36 clocks
    set_op(1'b0, 1'b1, 1'b0, 1'b1);
    add_seq(1'b1);
    step_sw = 1'b1; tick(); step_sw = 1'b0;
    run_states("step_add_deref", 12, -1, -1, 1'b1, 12, 24);

    // Step: ld -> FETCH, LOAD, EXEC
    set_op(1'b0, 1'b0, 1'b0, 1'b0);
    seq[0] = ST_FETCH; seq[1] = ST_LOAD; seq[2] = ST_EXEC;
    step_sw = 1'b1; tick(); step_sw = 1'b0;
    run_states("step_ld", 3, -1, -1, 1'b1, 3, 0);

    // Run: jump repeats FETCH, EXEC; run dropped in the third instruction
    set_op(1'b1, 1'b0, 1'b0, 1'b0);
    for (int unsigned j = 0; j < 6; j++) seq[j] = (j % 2 == 0) ? ST_FETCH : ST_EXEC;
    run_sw = 1'b1; tick();
    run_states("run_jump", 6, 4, -1, 1'b1, 6, 0);

    // Run: add, run dropped during LOAD, step pulse in EXEC decide ignored
    set_op(1'b0, 1'b1, 1'b0, 1'b0);
    add_seq(1'b0);
    run_sw = 1'b1; tick();
    run_states("run_drop_add", 11, 1, 10, 1'b1, 11, 24);

    // run_sw and step_sw together: run wins, execution continues
    set_op(1'b1, 1'b0, 1'b0, 1'b0);
    seq[0] = ST_FETCH; seq[1] = ST_EXEC; seq[2] = ST_FETCH; seq[3] = ST_EXEC;
    run_sw = 1'b1; step_sw = 1'b1; tick(); step_sw = 1'b0;
    run_states("run_and_step", 4, 2, -1, 1'b1, 4, 0);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("final_idle", outs(), {ST_FETCH, 1'b0, 1'b1, 1'b0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
